run_scheduler: RTL and testbench
================================

Name: run_scheduler

Overview:
- Shares one processor core (restart/done handshake) between NREQ requesters, e.g. testbench program runners or a host loader.
- Round-robin arbitrates start requests, issues a one-cycle restart pulse to the core, waits for done, then returns a completion pulse and the measured run length to the granted requester.
- Sits between the requester side and the core's restart/done pins.

Parameters:
- NREQ, 4, number of requesters (2..8)
- CW, 16, width of run-length counter
- TIMEOUT, 1000, watchdog limit in cycles (used only with the optional feature)

Ports:
- clock  input  1  system clock, rising-edge
- init_n  input  1  reset, asynchronous, active-low
- req  input  NREQ  level request per requester; requester drops it on its cmpl pulse
- grant  output  NREQ  one-hot owner of the core, held from LAUNCH through FINISH
- proc_restart  output  1  one-cycle restart pulse to the core
- proc_done  input  1  core done level
- busy  output  1  high whenever state != IDLE
- cmpl  output  NREQ  one-cycle pulse to the owner when its run ends
- run_cycles  output  CW  cycles counted in RUN for the last finished run; updated on the cmpl cycle, held otherwise
- timeout  output  1  one-cycle pulse alongside cmpl when the watchdog fired (optional feature only)

Behaviour:
- Reset (init_n low, asynchronous): state=IDLE; grant=0, proc_restart=0, busy=0, cmpl=0, run_cycles=0, timeout=0; round-robin pointer=NREQ-1, so requester 0 wins first.
- States: IDLE -> LAUNCH -> RUN -> FINISH -> IDLE.
- IDLE:
  - If req != 0, select the first set bit searching upward from pointer+1 with wrap.
  - Register grant one-hot; go to LAUNCH.
  - If req == 0, stay in IDLE.
- LAUNCH (1 cycle):
  - proc_restart=1; counter cleared to 0; go to RUN.
  - proc_done is ignored here, because a stale done may remain high from the previous run.
- RUN:
  - Counter increments every cycle and saturates at 2^CW-1.
  - proc_done is ignored while counter==0, i.e. on the first RUN cycle.
  - When counter>0 and proc_done=1, go to FINISH.
- FINISH (1 cycle):
  - cmpl[owner]=1; run_cycles=counter.
  - pointer=owner index; grant cleared at the end of the cycle; go to IDLE.
- Latency: a request seen in IDLE at cycle T gives grant at T+1 and proc_restart at T+1. proc_done first seen at RUN cycle k (k>=1) gives cmpl one cycle later with run_cycles=k.
- Req changes after grant (drop or new bits) never abort or alter the current run. A req still held after cmpl counts as a new request in the next IDLE arbitration.
- Simultaneous requests: strict round-robin; no requester waits more than NREQ-1 runs.
- Minimum gap between runs: FINISH->IDLE->LAUNCH, so 2 cycles with proc_restart low.
- Reset asserted mid-run: everything returns to reset values immediately; no cmpl is emitted.

Optional Feature:
- Macro: RUN_SCHED_WATCHDOG_EN.
- Defined:
  - In RUN, when counter reaches TIMEOUT without a qualifying proc_done, go to FINISH.
  - cmpl and timeout pulse together; run_cycles=TIMEOUT.
  - timeout is 0 on normal completion.
- Undefined:
  - No timeout port, no TIMEOUT compare logic.
  - RUN waits indefinitely; the counter still saturates.

Decomposition:
- Shared header run_sched_defs.vh holds:
  - state encodings ST_IDLE=2'd0, ST_LAUNCH=2'd1, ST_RUN=2'd2, ST_FINISH=2'd3
  - default NREQ, CW, TIMEOUT values
- Sub-module rr_arbiter:
  - Combinational: req and pointer in, one-hot grant plus index out.
  - Instantiated once; the state machine, counter and registers stay in run_scheduler.

Test Plan:
- Reset check: init_n low for 2 cycles with req=4'b1111 -> all outputs 0 until release; first grant=4'b0001 one cycle after release, with proc_restart pulsing in the same cycle.
- Single run: req=4'b0100, proc_done model raises done 10 cycles after proc_restart -> cmpl=4'b0100 for exactly one cycle, run_cycles=10, busy low the next cycle.
- Round-robin: req=4'b1011 held for 4 runs -> grant order 0001, 0010, 1000, 0001.
- Stale done: proc_done held high through LAUNCH and the first RUN cycle -> no FINISH before run_cycles=1; completion with run_cycles=1.
- Reset mid-run: init_n low at RUN counter=5 -> grant=0, busy=0, no cmpl; the next request restarts arbitration from requester 0.
- Watchdog (RUN_SCHED_WATCHDOG_EN, TIMEOUT=20): proc_done never asserted -> cmpl and timeout pulse together with run_cycles=20; without the macro, busy stays high for more than 100 cycles.

Source files
------------

// File: rtl/run_scheduler_pkg.sv
// Shared state encodings and default sizing for the run scheduler.
package run_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_RUN    = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

  localparam int DEF_NREQ    = 4;
  localparam int DEF_CW      = 16;
  localparam int DEF_TIMEOUT = 1000;

endpackage

// File: rtl/run_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first set request searching upward from i_ptr+1 with wrap.
module rr_arbiter
  import run_scheduler_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IW-1:0]   i_ptr,
  output logic [NREQ-1:0] o_grant,
  output logic [IW-1:0]   o_idx,
  output logic            o_valid
);

  logic [IW-1:0] w_pos;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    w_pos   = '0;
    for (int i = 1; i <= NREQ; i++) begin
      w_pos = IW'((int'(i_ptr) + i) % NREQ);
      if (!o_valid && i_req[w_pos]) begin
        o_valid        = 1'b1;
        o_grant[w_pos] = 1'b1;
        o_idx          = w_pos;
      end
    end
  end

endmodule

// File: rtl/run_scheduler.sv
// Shares one core's restart/done handshake between NREQ round-robin requesters.
// Optional watchdog (timeout port, TIMEOUT parameter) enabled by RUN_SCHED_WATCHDOG_EN.
module run_scheduler
  import run_scheduler_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int CW   = DEF_CW
`ifdef RUN_SCHED_WATCHDOG_EN
  ,parameter int TIMEOUT = DEF_TIMEOUT
`endif
) (
  input  logic            clock,
  input  logic            init_n,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] grant,
  output logic            proc_restart,
  input  logic            proc_done,
  output logic            busy,
  output logic [NREQ-1:0] cmpl,
  output logic [CW-1:0]   run_cycles
`ifdef RUN_SCHED_WATCHDOG_EN
  ,output logic           timeout
`endif
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t          r_state, w_next;
  logic [NREQ-1:0] r_grant;
  logic [IW-1:0]   r_owner, r_ptr;
  logic [CW-1:0]   r_cnt, r_run_cycles;
  logic [NREQ-1:0] w_arb_grant;
  logic [IW-1:0]   w_arb_idx;
  logic            w_arb_valid;
  logic            w_done_ok;
  logic            w_finish;

  rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
    .i_req   (req),
    .i_ptr   (r_ptr),
    .o_grant (w_arb_grant),
    .o_idx   (w_arb_idx),
    .o_valid (w_arb_valid)
  );

  // A done seen while the counter is still 0 may be left over from the previous run.
  assign w_done_ok = proc_done && (r_cnt != '0);

`ifdef RUN_SCHED_WATCHDOG_EN
  logic r_timeout;
  logic w_expired;
  assign w_expired = (r_cnt == CW'(TIMEOUT));
  assign w_finish  = w_done_ok || w_expired;
  assign timeout   = (r_state == ST_FINISH) && r_timeout;
`else
  assign w_finish  = w_done_ok;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (w_arb_valid) w_next = ST_LAUNCH;
      ST_LAUNCH: w_next = ST_RUN;
      ST_RUN:    if (w_finish) w_next = ST_FINISH;
      ST_FINISH: w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge init_n) begin
    if (!init_n) r_state <= ST_IDLE;
    else         r_state <= w_next;
  end

  always_ff @(posedge clock or negedge init_n) begin
    if (!init_n) begin
      r_grant      <= '0;
      r_owner      <= '0;
      r_ptr        <= IW'(NREQ - 1);
      r_cnt        <= '0;
      r_run_cycles <= '0;
`ifdef RUN_SCHED_WATCHDOG_EN
      r_timeout    <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_arb_valid) begin
            r_grant <= w_arb_grant;
            r_owner <= w_arb_idx;
          end
        end
        ST_LAUNCH: r_cnt <= '0;
        ST_RUN: begin
          if (r_cnt != '1) r_cnt <= r_cnt + 1'b1;
          if (w_finish) begin
            r_run_cycles <= r_cnt;
`ifdef RUN_SCHED_WATCHDOG_EN
            r_timeout    <= w_expired && !w_done_ok;
`endif
          end
        end
        ST_FINISH: begin
          r_ptr   <= r_owner;
          r_grant <= '0;
        end
        default: r_grant <= '0;
      endcase
    end
  end

  assign grant        = r_grant;
  assign proc_restart = (r_state == ST_LAUNCH);
  assign busy         = (r_state != ST_IDLE);
  assign cmpl         = (r_state == ST_FINISH) ? r_grant : '0;
  assign run_cycles   = r_run_cycles;

endmodule

// File: tb/tb_run_scheduler.sv
// Scoreboard bench for run_scheduler: directed runs push expected completions, a monitor checks cmpl pulses.
module tb_run_scheduler;

  localparam int NREQ = 4;
  localparam int CW   = 16;

  logic            clock = 1'b0;
  logic            init_n;
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] grant;
  logic            proc_restart;
  logic            proc_done;
  logic            busy;
  logic [NREQ-1:0] cmpl;
  logic [CW-1:0]   run_cycles;
`ifdef RUN_SCHED_WATCHDOG_EN
  logic            timeout;
`endif

  typedef struct {
    logic [NREQ-1:0] owner;
    int              cyc;
    bit              to;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clock = ~clock;

  run_scheduler #(
    .NREQ(NREQ),
    .CW(CW)
`ifdef RUN_SCHED_WATCHDOG_EN
    ,.TIMEOUT(20)
`endif
  ) dut (
    .clock        (clock),
    .init_n       (init_n),
    .req          (req),
    .grant        (grant),
    .proc_restart (proc_restart),
    .proc_done    (proc_done),
    .busy         (busy),
    .cmpl         (cmpl),
    .run_cycles   (run_cycles)
`ifdef RUN_SCHED_WATCHDOG_EN
    ,.timeout     (timeout)
`endif
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: every cmpl pulse must match the oldest outstanding expectation.
  always @(negedge clock) begin
    exp_t e;
    if (init_n && cmpl != '0) begin
      if (sb.size() == 0) begin
        checkOutput("unexpectedCmpl", 32'(cmpl), 32'd0);
      end else begin
        e = sb.pop_front();
        checkOutput("cmplOwner", 32'(cmpl), 32'(e.owner));
        checkOutput("runCycles", 32'(run_cycles), 32'(e.cyc));
`ifdef RUN_SCHED_WATCHDOG_EN
        checkOutput("timeoutFlag", 32'(timeout), 32'(e.to));
`endif
      end
    end
  end

  task automatic waitRestart();
    bit seen = 0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clock);
      if (proc_restart) seen = 1;
    end
    checkOutput("restartSeen", 32'(seen), 32'd1);
  endtask

  task automatic waitCmpl(input int limit);
    bit seen = 0;
    for (int n = 0; n < limit && !seen; n++) begin
      @(negedge clock);
      if (cmpl != '0) seen = 1;
    end
    checkOutput("cmplSeen", 32'(seen), 32'd1);
    proc_done = 1'b0;
    @(negedge clock);
    checkOutput("cmplOnePulse", 32'(cmpl), 32'd0);
    checkOutput("idleAfterRun", 32'(busy), 32'd0);
  endtask

  task automatic raiseDone(input int d);
    repeat (d + 1) @(posedge clock);
    #1 proc_done = 1'b1;
  endtask

  task automatic applyStimulus(input logic [NREQ-1:0] r, input int d,
                               input logic [NREQ-1:0] expGrant, input bit stale);
    req = r;
    sb.push_back('{expGrant, d, 1'b0});
    if (stale) proc_done = 1'b1;
    waitRestart();
    checkOutput("grant", 32'(grant), 32'(expGrant));
    if (!stale) raiseDone(d);
    waitCmpl(d + 10);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL globalTimeout actual=running required=finished");
    $fatal(1, "[TB] simulation time limit");
  end

  initial begin
    logic [NREQ-1:0] rrGrant[4];
    int              rrDelay[4];
    int              busyCnt;
    rrGrant = '{4'b0001, 4'b0010, 4'b1000, 4'b0001};
    rrDelay = '{2, 5, 1, 4};

    init_n    = 1'b0;
    req       = 4'b1111;
    proc_done = 1'b0;
    repeat (2) begin
      @(negedge clock);
      checkOutput("rstGrant",     32'(grant),        32'd0);
      checkOutput("rstRestart",   32'(proc_restart), 32'd0);
      checkOutput("rstBusy",      32'(busy),         32'd0);
      checkOutput("rstCmpl",      32'(cmpl),         32'd0);
      checkOutput("rstRunCycles", 32'(run_cycles),   32'd0);
    end
    init_n = 1'b1;
    sb.push_back('{4'b0001, 3, 1'b0});
    @(negedge clock);
    checkOutput("firstGrant",   32'(grant),        32'b0001);
    checkOutput("firstRestart", 32'(proc_restart), 32'd1);
    raiseDone(3);
    waitCmpl(13);

    applyStimulus(4'b0100, 10, 4'b0100, 1'b0);
    applyStimulus(4'b0010, 1,  4'b0010, 1'b1);

    // Reset during RUN with counter at 5: nothing completes, pointer returns to NREQ-1.
    req = 4'b1000;
    waitRestart();
    checkOutput("midGrant", 32'(grant), 32'b1000);
    repeat (6) @(negedge clock);
    init_n = 1'b0;
    #1;
    checkOutput("midRstGrant",     32'(grant),      32'd0);
    checkOutput("midRstBusy",      32'(busy),       32'd0);
    checkOutput("midRstCmpl",      32'(cmpl),       32'd0);
    checkOutput("midRstRunCycles", 32'(run_cycles), 32'd0);
    req = '0;
    @(negedge clock);
    init_n = 1'b1;

    for (int k = 0; k < 4; k++) applyStimulus(4'b1011, rrDelay[k], rrGrant[k], 1'b0);

    // Core never answers; the request is dropped mid-run and must not abort it.
    req = 4'b0100;
`ifdef RUN_SCHED_WATCHDOG_EN
    sb.push_back('{4'b0100, 20, 1'b1});
`endif
    waitRestart();
    checkOutput("stallGrant", 32'(grant), 32'b0100);
    req = '0;
`ifdef RUN_SCHED_WATCHDOG_EN
    waitCmpl(40);
`else
    busyCnt = 0;
    repeat (120) begin
      @(negedge clock);
      if (busy) busyCnt++;
    end
    checkOutput("busyHeld", 32'(busyCnt), 32'd120);
`endif

    checkOutput("scoreboardEmpty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
